fu_issue_queue: RTL
===================

Name: fu_issue_queue

Overview:
- Reservation station directly upstream of a functional unit such as the logical unit.
- Accepts renamed instructions from dispatch and holds them until all source operands are ready.
- Captures operand values from the common data bus (CDB) broadcasts.
- Issues one instruction per cycle, with captured values, into the FU's fu_if-style inputs whenever the FU reports ready.

Parameters:
- DEPTH, 8, number of entries (power of two, >=2)
- XLEN, 64, operand/data width
- PRN_W, 7, physical register number width
- ID_W, 6, instruction id width
- CDB_N, 2, number of CDB broadcast ports

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_inst  in  32  instruction word
- disp_inst_id  in  ID_W  instruction id
- disp_out_prn  in  PRN_W  destination PRN
- disp_src_prn  in  3*PRN_W  source PRNs [0..2]
- disp_src_rdy  in  3  source already ready (or unused)
- disp_src_val  in  3*XLEN  value when rdy
- cdb_valid  in  CDB_N  broadcast valid per port
- cdb_prn  in  CDB_N*PRN_W  broadcast PRN
- cdb_data  in  CDB_N*XLEN  broadcast value
- fu_ready  in  1  FU can accept this cycle
- iss_valid  out  1  maps to fu.inst_valid
- iss_inst  out  32  maps to fu.inst
- iss_op  out  3*XLEN  maps to fu.op[0..2]
- iss_out_prn  out  PRN_W  maps to fu.out_prn
- iss_inst_id  out  ID_W  maps to fu.inst_id

Behaviour:
- Reset (rst=1 at a clk edge):
  - All entry valid bits cleared; all iss_* outputs driven to 0.
  - disp_ready=1 from the next cycle.
- Entry contents: valid, inst, inst_id, out_prn, and per source {prn, rdy, val}.
- Allocation:
  - Dispatch is accepted when disp_valid && disp_ready.
  - The accepted instruction is written into the lowest-index free entry.
  - disp_ready = any entry free, computed from registered state only; an entry freed by an issue in the same cycle is not counted.
- Wakeup:
  - Each cycle, for every valid entry and every source with rdy=0, a cdb_valid[k] with a matching cdb_prn[k] sets rdy=1 and val=cdb_data[k].
  - If several ports match, the lowest k wins.
  - PRN 0 is never woken by the CDB.
- Dispatch bypass: a dispatched source with rdy=0 whose PRN matches a CDB port in the same cycle is stored with rdy=1 and the CDB value.
- Selection:
  - An entry is eligible when valid and all 3 sources are rdy. Entries written or woken this cycle are eligible from the next cycle, not the same one.
  - If fu_ready=1 and an eligible entry exists, the lowest-index eligible entry is selected. Its fields are registered onto iss_* and the entry is freed at the same edge.
- Issue output and latency:
  - iss_valid is a one-cycle pulse per issued instruction.
  - With fu_ready=0 or no eligible entry, iss_valid=0 and the other iss_* outputs hold their last values.
  - Minimum latency: dispatch of an all-ready instruction at edge N gives iss_valid=1 after edge N+1.
- Simultaneous issue and dispatch: allowed in the same cycle, including when full. The freed slot is not reused by that same cycle's dispatch.
- Flush:
  - At the edge, all entries are invalidated and iss_valid is set to 0.
  - A dispatch in the flush cycle is dropped.
  - Flush has priority over wakeup and dispatch.
- Reset mid-operation: same as reset; pending entries are lost with no issue.
- Ordering: no age ordering guarantee beyond the index priority above. The FU is order-agnostic and the ROB handles ordering.

Decomposition:
- Shared package (e.g. ooo_pkg):
  - XLEN, PRN_W, ID_W widths
  - rs_entry_t struct (valid, inst, inst_id, out_prn, src prn/rdy/val arrays)
  - cdb_t struct
- One natural sub-module, rs_priority_enc:
  - Parameterized lowest-set-bit finder returning {found, index}.
  - Instantiated twice: once for the free-slot search, once for the eligible-entry select.

Test Plan:
- Reset, then dispatch CSEL (inst=0x9A820020, all rdy, vals 0x11/0x22/0x0) with fu_ready=1 -> iss_valid=1 exactly one cycle later with iss_op={0x11,0x22,0x0}, iss_out_prn and iss_inst_id matching dispatch.
- Dispatch with src1 rdy=0, prn=5; three cycles later cdb_valid[1]=1, prn=5, data=0xDEAD -> iss_valid the cycle after the wakeup, with iss_op[1]=0xDEAD; no issue earlier.
- Same-cycle bypass: dispatch src0 prn=9 rdy=0 while the CDB broadcasts prn 9 = 0x77 -> entry issues next cycle with op[0]=0x77.
- Fill all 8 entries with non-ready ops -> disp_ready=0 after the 8th accept. Then wake entry 3 -> it issues; disp_ready returns to 1 the following cycle; the next dispatch lands in entry 3.
- Hold fu_ready=0 with 2 eligible entries -> iss_valid stays 0 and the outputs are stable. Raise fu_ready -> entry 0 issues first, then entry 1 on the next cycle.
- Flush with 4 entries pending and a concurrent dispatch -> no iss_valid afterwards; disp_ready=1; a later dispatch lands in entry 0.

Source files
------------

// File: rtl/fu_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// fu_issue_queue_pkg
//   Shared widths and types for the functional-unit issue queue.
//   - IQ_XLEN / IQ_PRN_W / IQ_ID_W : datapath, physical-register and id widths.
//     The entry struct is built from these, so the top-level width
//     parameters must keep these values.
//   - rs_entry_t : one reservation-station slot (valid, instruction, id,
//     destination PRN, per-source {prn, rdy, val}).
//   - cdb_t      : one common-data-bus broadcast port.
//   - cdb_hit()  : true when a broadcast wakes a given source PRN.
// -----------------------------------------------------------------------------
package fu_issue_queue_pkg;

  localparam int IQ_XLEN  = 64;
  localparam int IQ_PRN_W = 7;
  localparam int IQ_ID_W  = 6;
  localparam int IQ_NSRC  = 3;
  localparam int IQ_INSTW = 32;

  typedef struct packed {
    logic                              valid;
    logic [IQ_INSTW-1:0]               inst;
    logic [IQ_ID_W-1:0]                inst_id;
    logic [IQ_PRN_W-1:0]               out_prn;
    logic [IQ_NSRC-1:0][IQ_PRN_W-1:0]  src_prn;
    logic [IQ_NSRC-1:0]                src_rdy;
    logic [IQ_NSRC-1:0][IQ_XLEN-1:0]   src_val;
  } rs_entry_t;

  typedef struct packed {
    logic                valid;
    logic [IQ_PRN_W-1:0] prn;
    logic [IQ_XLEN-1:0]  data;
  } cdb_t;

  // PRN 0 is the hard-wired zero register: a broadcast never wakes it.
  function automatic logic cdb_hit(cdb_t c, logic [IQ_PRN_W-1:0] prn);
    return c.valid && (c.prn == prn) && (prn != '0);
  endfunction

endpackage

// File: rtl/fu_issue_queue_priority_enc.sv
// -----------------------------------------------------------------------------
// rs_priority_enc
//   Lowest-set-bit finder.
//   - req   : request vector, bit 0 has the highest priority
//   - found : at least one request bit is set
//   - idx   : index of the lowest set bit (0 when found=0)
// -----------------------------------------------------------------------------
module rs_priority_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    found = |req;
    idx   = '0;
    // Scan from the top so the lowest set bit is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/fu_issue_queue.sv
// -----------------------------------------------------------------------------
// fu_issue_queue
//   Reservation station in front of a functional unit. Holds renamed
//   instructions until all three sources are ready, snoops the CDB for
//   operand values, and issues one instruction per cycle to the FU.
//   Ports:
//   - clk, rst        : clock, synchronous active-high reset
//   - flush           : squash every entry (drops a same-cycle dispatch)
//   - disp_*          : dispatch handshake and instruction payload
//   - cdb_*           : CDB_N broadcast ports {valid, prn, data}, flattened
//   - fu_ready        : FU accepts an instruction this cycle
//   - iss_*           : registered issue outputs; iss_valid is a 1-cycle pulse
// -----------------------------------------------------------------------------
module fu_issue_queue
  import fu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = IQ_XLEN,
  parameter int PRN_W = IQ_PRN_W,
  parameter int ID_W  = IQ_ID_W,
  parameter int CDB_N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [31:0]          disp_inst,
  input  logic [ID_W-1:0]      disp_inst_id,
  input  logic [PRN_W-1:0]     disp_out_prn,
  input  logic [3*PRN_W-1:0]   disp_src_prn,
  input  logic [2:0]           disp_src_rdy,
  input  logic [3*XLEN-1:0]    disp_src_val,
  input  logic [CDB_N-1:0]     cdb_valid,
  input  logic [CDB_N*PRN_W-1:0] cdb_prn,
  input  logic [CDB_N*XLEN-1:0]  cdb_data,
  input  logic                 fu_ready,
  output logic                 iss_valid,
  output logic [31:0]          iss_inst,
  output logic [3*XLEN-1:0]    iss_op,
  output logic [PRN_W-1:0]     iss_out_prn,
  output logic [ID_W-1:0]      iss_inst_id
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t entries_q   [DEPTH];
  rs_entry_t entries_d   [DEPTH];
  rs_entry_t entries_clr [DEPTH];
  rs_entry_t disp_entry;
  cdb_t      cdb         [CDB_N];

  logic [DEPTH-1:0] free_vec, elig_vec;
  logic             free_found, elig_found;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             do_issue, do_disp;

  logic              iss_valid_q, iss_valid_d;
  logic [31:0]       iss_inst_q, iss_inst_d;
  logic [3*XLEN-1:0] iss_op_q, iss_op_d;
  logic [PRN_W-1:0]  iss_out_prn_q, iss_out_prn_d;
  logic [ID_W-1:0]   iss_inst_id_q, iss_inst_id_d;

  always_comb begin
    for (int k = 0; k < CDB_N; k++) begin
      cdb[k].valid = cdb_valid[k];
      cdb[k].prn   = cdb_prn[k*PRN_W +: PRN_W];
      cdb[k].data  = cdb_data[k*XLEN +: XLEN];
    end
  end

  // Free and eligible vectors look only at registered state, so a slot
  // freed or woken this cycle is not visible until the next one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = !entries_q[i].valid;
      elig_vec[i] = entries_q[i].valid && (&entries_q[i].src_rdy);
    end
  end

  rs_priority_enc #(.N(DEPTH)) u_free_enc (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_priority_enc #(.N(DEPTH)) u_sel_enc (
    .req   (elig_vec),
    .found (elig_found),
    .idx   (sel_idx)
  );

  assign disp_ready = free_found;
  assign do_issue   = fu_ready && elig_found && !flush;
  assign do_disp    = disp_valid && disp_ready && !flush;

  // Incoming entry, with same-cycle CDB bypass for sources not yet ready.
  always_comb begin
    disp_entry         = '0;
    disp_entry.valid   = 1'b1;
    disp_entry.inst    = disp_inst;
    disp_entry.inst_id = disp_inst_id;
    disp_entry.out_prn = disp_out_prn;
    for (int s = 0; s < 3; s++) begin
      disp_entry.src_prn[s] = disp_src_prn[s*PRN_W +: PRN_W];
      disp_entry.src_rdy[s] = disp_src_rdy[s];
      disp_entry.src_val[s] = disp_src_val[s*XLEN +: XLEN];
      if (!disp_src_rdy[s]) begin
        // Descending scan: the lowest matching port is applied last.
        for (int k = CDB_N - 1; k >= 0; k--) begin
          if (cdb_hit(cdb[k], disp_src_prn[s*PRN_W +: PRN_W])) begin
            disp_entry.src_rdy[s] = 1'b1;
            disp_entry.src_val[s] = cdb[k].data;
          end
        end
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    // Wakeup of resident entries.
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (entries_q[i].valid && !entries_q[i].src_rdy[s]) begin
          for (int k = CDB_N - 1; k >= 0; k--) begin
            if (cdb_hit(cdb[k], entries_q[i].src_prn[s])) begin
              entries_d[i].src_rdy[s] = 1'b1;
              entries_d[i].src_val[s] = cdb[k].data;
            end
          end
        end
      end
    end
    // free_idx always points at a slot that was empty in registered state,
    // so it can never collide with the slot being issued.
    if (do_issue) entries_d[sel_idx].valid = 1'b0;
    if (do_disp)  entries_d[free_idx]      = disp_entry;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
    end
  end

  // Reset image: valid bits cleared, payload left as-is.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_clr[i]       = entries_q[i];
      entries_clr[i].valid = 1'b0;
    end
  end

  always_comb begin
    iss_valid_d   = do_issue;
    iss_inst_d    = iss_inst_q;
    iss_op_d      = iss_op_q;
    iss_out_prn_d = iss_out_prn_q;
    iss_inst_id_d = iss_inst_id_q;
    if (do_issue) begin
      iss_inst_d    = entries_q[sel_idx].inst;
      iss_op_d      = entries_q[sel_idx].src_val;
      iss_out_prn_d = entries_q[sel_idx].out_prn;
      iss_inst_id_d = entries_q[sel_idx].inst_id;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    if (rst) begin
      // NOTE: only the valid bits need a reset; payload storage is don't-care
      // while invalid, so it is not cleared.
      entries_q     <= entries_clr;
      iss_valid_q   <= 1'b0;
      iss_inst_q    <= '0;
      iss_op_q      <= '0;
      iss_out_prn_q <= '0;
      iss_inst_id_q <= '0;
    end else begin
      entries_q     <= entries_d;
      iss_valid_q   <= iss_valid_d;
      iss_inst_q    <= iss_inst_d;
      iss_op_q      <= iss_op_d;
      iss_out_prn_q <= iss_out_prn_d;
      iss_inst_id_q <= iss_inst_id_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_inst    = iss_inst_q;
  assign iss_op      = iss_op_q;
  assign iss_out_prn = iss_out_prn_q;
  assign iss_inst_id = iss_inst_id_q;

endmodule
